// File: rtl/vga_pattern_engine.sv
// VGA timing counters, frame-synchronous byte-stream configuration and four
// pattern sources feeding a 2-stage pipeline that keeps syncs aligned with colour.
module vga_pattern_engine #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int COLOR_BITS = 2,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_valid_i,
  input  logic [7:0]            cfg_data_i,
  input  logic                  cfg_sync_i,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic                  active_o,
  output logic [COLOR_BITS-1:0] red_o,
  output logic [COLOR_BITS-1:0] green_o,
  output logic [COLOR_BITS-1:0] blue_o,
  output logic                  frame_start_o,
  output logic                  cfg_applied_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // At least 10 bits so the checker can index bit 9 for any geometry
  localparam int HW = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
  localparam int VW = ($clog2(V_TOTAL) > 10) ? $clog2(V_TOTAL) : 10;
  localparam int CB = COLOR_BITS;
  localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [1:0] MODE_SOLID = 2'd0;
  localparam logic [1:0] MODE_NOISE = 2'd1;
  localparam logic [1:0] MODE_BARS  = 2'd2;
  localparam logic [1:0] MODE_CHECK = 2'd3;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          vis_s, hsync_s, vsync_s, origin_s, apply_s;

  logic [1:0]    cnt_q, cnt_d;
  logic [23:0]   shift_q, shift_d;
  logic [31:0]   pend_q, pend_d, live_q, live_d, eff_s;
  logic          flag_q, flag_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [23:0]   noise_s;

  logic [1:0]    mode_s;
  logic [3:0]    size_s, tile_n_s;
  logic          tile_s;
  logic [2:0]    bar_idx_s;
  logic [CB-1:0] col_r_s, col_g_s, col_b_s;
  logic [CB-1:0] pix_r_s, pix_g_s, pix_b_s;
  logic          cfg_unused_s;

  logic          s1_hs_q, s1_vs_q, s1_act_q, s1_fs_q;
  logic [CB-1:0] s1_r_q, s1_g_q, s1_b_q;
  logic          hs_q, vs_q, act_q, fs_q, applied_q;
  logic [CB-1:0] r_q, g_q, b_q;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        v_d = '0;
      end else begin
        v_d = v_q + VW'(1);
      end
    end else begin
      h_d = h_q + HW'(1);
    end
  end

  assign vis_s    = (h_q < H_VIS_END) && (v_q < V_VIS_END);
  assign hsync_s  = (h_q >= HS_BEGIN) && (h_q < HS_END);
  assign vsync_s  = (v_q >= VS_BEGIN) && (v_q < VS_END);
  assign origin_s = (h_q == '0) && (v_q == '0);
  assign apply_s  = origin_s && flag_q;

  // Apply happens before byte intake, so a word completing at (0,0) stays pending
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    pend_d  = pend_q;
    flag_d  = flag_q;
    live_d  = live_q;
    if (apply_s) begin
      live_d = pend_q;
      flag_d = 1'b0;
    end else begin
      live_d = live_q;
    end
    if (cfg_sync_i) begin
      cnt_d   = 2'd0;
      shift_d = 24'd0;
    end else if (cfg_valid_i) begin
      shift_d = {shift_q[15:0], cfg_data_i};
      if (cnt_q == 2'd3) begin
        pend_d = {shift_q, cfg_data_i};
        flag_d = 1'b1;
        cnt_d  = 2'd0;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign lfsr_d = vis_s ? {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]} : lfsr_q;

  // The word going live this cycle already colours pixel (0,0)
  assign eff_s    = apply_s ? pend_q : live_q;
  assign mode_s   = eff_s[31:30];
  assign size_s   = eff_s[29:26];
  assign tile_n_s = (size_s > 4'd9) ? 4'd9 : size_s;
  assign tile_s   = h_q[tile_n_s] ^ v_q[tile_n_s];
  assign col_r_s  = eff_s[23 -: CB];
  assign col_g_s  = eff_s[15 -: CB];
  assign col_b_s  = eff_s[7 -: CB];
  assign noise_s  = {8'd0, lfsr_q};
  assign cfg_unused_s = ^{eff_s, noise_s};

  always_comb begin
    bar_idx_s = 3'd0;
    for (int k = 1; k < 8; k++) begin
      bar_idx_s = bar_idx_s + ((int'(h_q) >= k * BAR_W) ? 3'd1 : 3'd0);
    end
  end

  always_comb begin
    pix_r_s = '0;
    pix_g_s = '0;
    pix_b_s = '0;
    case (mode_s)
      MODE_SOLID: begin
        pix_r_s = col_r_s;
        pix_g_s = col_g_s;
        pix_b_s = col_b_s;
      end
      MODE_NOISE: begin
        pix_r_s = noise_s[3*CB-1 -: CB];
        pix_g_s = noise_s[2*CB-1 -: CB];
        pix_b_s = noise_s[CB-1 -: CB];
      end
      MODE_BARS: begin
        pix_r_s = {CB{bar_idx_s[2]}};
        pix_g_s = {CB{bar_idx_s[1]}};
        pix_b_s = {CB{bar_idx_s[0]}};
      end
      MODE_CHECK: begin
        pix_r_s = tile_s ? col_r_s : '0;
        pix_g_s = tile_s ? col_g_s : '0;
        pix_b_s = tile_s ? col_b_s : '0;
      end
      default: begin
        pix_r_s = '0;
        pix_g_s = '0;
        pix_b_s = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_q     <= '0;
      v_q     <= '0;
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
      pend_q  <= 32'd0;
      live_q  <= 32'd0;
      flag_q  <= 1'b0;
      lfsr_q  <= 16'hACE1;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      pend_q  <= pend_d;
      live_q  <= live_d;
      flag_q  <= flag_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Stage 1 samples the counter-domain view, stage 2 blanks colour outside the visible area
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_hs_q   <= ~SYNC_POL;
      s1_vs_q   <= ~SYNC_POL;
      s1_act_q  <= 1'b0;
      s1_fs_q   <= 1'b0;
      s1_r_q    <= '0;
      s1_g_q    <= '0;
      s1_b_q    <= '0;
      hs_q      <= ~SYNC_POL;
      vs_q      <= ~SYNC_POL;
      act_q     <= 1'b0;
      fs_q      <= 1'b0;
      applied_q <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      s1_hs_q   <= hsync_s ? SYNC_POL : ~SYNC_POL;
      s1_vs_q   <= vsync_s ? SYNC_POL : ~SYNC_POL;
      s1_act_q  <= vis_s;
      s1_fs_q   <= origin_s;
      s1_r_q    <= pix_r_s;
      s1_g_q    <= pix_g_s;
      s1_b_q    <= pix_b_s;
      hs_q      <= s1_hs_q;
      vs_q      <= s1_vs_q;
      act_q     <= s1_act_q;
      fs_q      <= s1_fs_q;
      applied_q <= apply_s;
      r_q       <= s1_act_q ? s1_r_q : '0;
      g_q       <= s1_act_q ? s1_g_q : '0;
      b_q       <= s1_act_q ? s1_b_q : '0;
    end
  end

  assign hs_o          = hs_q;
  assign vs_o          = vs_q;
  assign active_o      = act_q;
  assign red_o         = r_q;
  assign green_o       = g_q;
  assign blue_o        = b_q;
  assign frame_start_o = fs_q;
  assign cfg_applied_o = applied_q;

endmodule

// File: tb/tb_vga_pattern_engine.sv
// Bench for vga_pattern_engine on a reduced 80x22 raster: directed scenarios plus
// randomized configuration words against a cycle-position reference model.
module tb_vga_pattern_engine;

  localparam int HA = 64, HFP = 4, HSY = 8, HBP = 4;
  localparam int VA = 16, VFP = 2, VSY = 2, VBP = 2;
  localparam int CB = 2;
  localparam bit POL = 1'b0;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FR = HT * VT;
  localparam int CMAX = (1 << CB) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic [7:0]    cfg_data;
  logic          cfg_sync;
  logic          hs, vs, active, frame_start, cfg_applied;
  logic [CB-1:0] red, green, blue;

  vga_pattern_engine #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .COLOR_BITS(CB), .SYNC_POL(POL)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_valid_i(cfg_valid), .cfg_data_i(cfg_data), .cfg_sync_i(cfg_sync),
    .hs_o(hs), .vs_o(vs), .active_o(active),
    .red_o(red), .green_o(green), .blue_o(blue),
    .frame_start_o(frame_start), .cfg_applied_o(cfg_applied)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          hs, vs, act, fs;
    logic [CB-1:0] r, g, b;
    int            h, v;
  } exp_t;

  exp_t        pipe[$];
  logic [7:0]  m_bytes[$];
  logic [31:0] m_live, m_pend;
  logic [15:0] m_lfsr;
  bit          m_flag;
  int          t, n_total, n_pass, applied_cnt, cur_h, cur_v;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] fb;
    fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h0001;
    return (s >> 1) | (fb << 15);
  endfunction

  function automatic exp_t idle_entry();
    exp_t e;
    e.hs = ~POL; e.vs = ~POL; e.act = 1'b0; e.fs = 1'b0;
    e.r = '0; e.g = '0; e.b = '0; e.h = -1; e.v = -1;
    return e;
  endfunction

  // Expected output for the pixel at raster position tt under config word w
  function automatic exp_t pixel(input int tt, input logic [31:0] w, input logic [15:0] lf);
    exp_t e;
    int mode, n, idx, val, sr, sg, sb, rr, gg, bb;
    e.h   = tt % HT;
    e.v   = (tt / HT) % VT;
    e.act = (e.h < HA) && (e.v < VA);
    e.hs  = (e.h >= HA + HFP && e.h < HA + HFP + HSY) ? POL : ~POL;
    e.vs  = (e.v >= VA + VFP && e.v < VA + VFP + VSY) ? POL : ~POL;
    e.fs  = (tt % FR) == 0;
    mode = int'(w[31:30]);
    sr = int'(w[23:16]) >> (8 - CB);
    sg = int'(w[15:8]) >> (8 - CB);
    sb = int'(w[7:0]) >> (8 - CB);
    rr = 0; gg = 0; bb = 0;
    case (mode)
      0: begin rr = sr; gg = sg; bb = sb; end
      1: begin
        val = int'(lf) % (1 << (3 * CB));
        rr = val >> (2 * CB);
        gg = (val >> CB) % (1 << CB);
        bb = val % (1 << CB);
      end
      2: begin
        idx = e.h / (HA / 8);
        if (idx > 7) idx = 7;
        rr = ((idx / 4) % 2 == 1) ? CMAX : 0;
        gg = ((idx / 2) % 2 == 1) ? CMAX : 0;
        bb = (idx % 2 == 1) ? CMAX : 0;
      end
      default: begin
        n = int'(w[29:26]);
        if (n > 9) n = 9;
        if ((((e.h >> n) ^ (e.v >> n)) % 2) == 1) begin rr = sr; gg = sg; bb = sb; end
      end
    endcase
    if (!e.act) begin rr = 0; gg = 0; bb = 0; end
    e.r = CB'(rr); e.g = CB'(gg); e.b = CB'(bb);
    return e;
  endfunction

  task automatic model_reset();
    t = 0; m_live = 32'd0; m_pend = 32'd0; m_flag = 1'b0; m_lfsr = 16'hACE1;
    m_bytes.delete();
    pipe.delete();
    pipe.push_back(idle_entry());
  endtask

  // One clock: advance the model with the currently driven inputs, then compare outputs
  task automatic tick();
    exp_t e;
    bit   apl;
    apl = ((t % FR) == 0) && m_flag;
    e = pixel(t, apl ? m_pend : m_live, m_lfsr);
    pipe.push_back(e);
    if (apl) begin m_live = m_pend; m_flag = 1'b0; end
    if (cfg_sync) m_bytes.delete();
    else if (cfg_valid) begin
      m_bytes.push_back(cfg_data);
      if (m_bytes.size() == 4) begin
        m_pend = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
        m_flag = 1'b1;
        m_bytes.delete();
      end
    end
    if (e.act) m_lfsr = lfsr_step(m_lfsr);
    t++;
    @(posedge clk);
    #1;
    e = pipe.pop_front();
    cur_h = e.h; cur_v = e.v;
    if (cfg_applied === 1'b1) applied_cnt++;
    check($sformatf("stream@(%0d,%0d)", e.h, e.v),
          64'({hs, vs, active, frame_start, cfg_applied, red, green, blue}),
          64'({e.hs, e.vs, e.act, e.fs, apl, e.r, e.g, e.b}));
  endtask

  task automatic idle_ticks(input int n);
    cfg_valid = 1'b0; cfg_sync = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    cfg_valid = 1'b1; cfg_sync = 1'b0; cfg_data = b;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[31 - 8 * i -: 8]);
  endtask

  task automatic advance_to(input int phase);
    int k;
    k = 0; cfg_valid = 1'b0; cfg_sync = 1'b0;
    while ((t % FR) != phase && k < FR) begin tick(); k++; end
  endtask

  task automatic probe(input int ph, input int pv, input string tag,
                       input int er, input int eg, input int eb);
    int k;
    k = 0; cfg_valid = 1'b0; cfg_sync = 1'b0;
    do begin tick(); k++; end while (!(cur_h == ph && cur_v == pv) && k < 2 * FR + 4);
    check({tag, "_found"}, 64'(cur_h == ph && cur_v == pv), 64'd1);
    check({tag, "_rgb"}, 64'({red, green, blue}), 64'({CB'(er), CB'(eg), CB'(eb)}));
  endtask

  task automatic measure_frame();
    int k, hs_first, hs_cnt, vs_first, vs_cnt, fs_at;
    k = 0; cfg_valid = 1'b0; cfg_sync = 1'b0;
    do begin tick(); k++; end while (frame_start !== 1'b1 && k < 2 * FR + 4);
    check("m_fs_found", 64'(frame_start === 1'b1), 64'd1);
    hs_first = -1; vs_first = -1; hs_cnt = 0; vs_cnt = 0; fs_at = -1;
    for (int i = 1; i <= FR; i++) begin
      tick();
      if (hs === POL) begin hs_cnt++; if (hs_first < 0) hs_first = i; end
      if (vs === POL) begin vs_cnt++; if (vs_first < 0) vs_first = i; end
      if (frame_start === 1'b1 && fs_at < 0) fs_at = i;
    end
    check("frame_period", 64'(fs_at), 64'(FR));
    check("hs_first_h", 64'(hs_first), 64'(HA + HFP));
    check("hs_low_cycles", 64'(hs_cnt), 64'(HSY * VT));
    check("vs_first_cycle", 64'(vs_first), 64'((VA + VFP) * HT));
    check("vs_low_cycles", 64'(vs_cnt), 64'(VSY * HT));
  endtask

  initial begin
    logic [31:0] w;
    int a0;
    n_total = 0; n_pass = 0; applied_cnt = 0; cur_h = -1; cur_v = -1;
    cfg_valid = 1'b0; cfg_data = 8'd0; cfg_sync = 1'b0; rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({hs, vs, active, frame_start, cfg_applied, red, green, blue}),
          64'({~POL, ~POL, 3'b000, {(3 * CB){1'b0}}}));
    @(negedge clk);
    rst = 1'b0;

    // Syncs idle and colour black until the counters have been through two stages
    tick();
    check("t1_idle_syncs", 64'({hs, vs}), 64'({~POL, ~POL}));
    check("t1_idle_rgb", 64'({red, green, blue}), 64'd0);
    tick();
    check("t1_fs_after_2clk", 64'(frame_start), 64'd1);
    tick();
    check("t1_fs_single", 64'(frame_start), 64'd0);

    measure_frame();

    // Solid red, received mid-frame, goes live only at the next frame
    advance_to(2 * HT);
    a0 = applied_cnt;
    send_word(32'h00FF_0000);
    probe(10, 5, "t3_still_black", 0, 0, 0);
    check("t3_no_apply_yet", 64'(applied_cnt - a0), 64'd0);
    probe(0, 0, "t3_red", CMAX, 0, 0);
    idle_ticks(HT);
    check("t3_applied_once", 64'(applied_cnt - a0), 64'd1);

    advance_to(5 * HT);
    send_word(32'h8000_0000);
    probe(7, 0, "t4_bar0", 0, 0, 0);
    probe(8, 0, "t4_bar1", 0, 0, CMAX);
    probe(56, 0, "t4_bar7", CMAX, CMAX, CMAX);

    advance_to(5 * HT);
    send_word(32'hC8FF_FFFF);
    probe(0, 0, "t5_origin", 0, 0, 0);
    probe(4, 0, "t5_tile_on", CMAX, CMAX, CMAX);
    probe(4, 4, "t5_tile_off", 0, 0, 0);

    // Partial word discarded by cfg_sync; then a word whose last byte lands at (0,0)
    advance_to(5 * HT);
    send_byte(8'hAA);
    send_byte(8'hBB);
    cfg_sync = 1'b1; tick(); cfg_sync = 1'b0;
    send_word(32'h0000_FF00);
    probe(1, 0, "t6_green", 0, CMAX, 0);
    advance_to(FR - 3);
    a0 = applied_cnt;
    send_word(32'h00FF_0000);
    probe(3, 1, "t6_late_still_green", 0, CMAX, 0);
    check("t6_late_no_apply", 64'(applied_cnt - a0), 64'd0);
    probe(3, 1, "t6_late_red", CMAX, 0, 0);
    check("t6_late_applied", 64'(applied_cnt - a0), 64'd1);

    // Randomized words, gaps, stray bytes and sync collisions
    for (int i = 0; i < 12; i++) begin
      w = $urandom();
      if (i == 0) w[31:30] = 2'd1;
      if (i % 4 == 3) begin
        send_byte(8'($urandom()));
        cfg_valid = 1'b1; cfg_sync = 1'b1; cfg_data = 8'($urandom());
        tick();
        cfg_valid = 1'b0; cfg_sync = 1'b0;
      end
      for (int b = 0; b < 4; b++) begin
        send_byte(w[31 - 8 * b -: 8]);
        idle_ticks(int'($urandom_range(0, 3)));
      end
      idle_ticks((i == 0) ? FR + 100 : int'($urandom_range(100, 2200)));
    end

    // Asynchronous reset in the middle of a line
    advance_to(7 * HT + 20);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 64'({hs, vs, active, frame_start, cfg_applied, red, green, blue}),
          64'({~POL, ~POL, 3'b000, {(3 * CB){1'b0}}}));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    check("t8_fs_after_reset", 64'(frame_start), 64'd1);
    probe(8, 2, "t8_black", 0, 0, 0);
    idle_ticks(200);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
